i2c_master_writer: RTL

- I2C controller that drives the PID gain-configuration bus. Issues single-byte register writes and reads to the on-chip PID register slave at DEVICE_ADDRESS.
- Sits between the host/config logic and the SCL/SDA pads. It is the initiator end of the standard frame: 7-bit device address, R/W bit, 8-bit register address, 8-bit data, MSB first, with ACK after each byte.
- Reads use a repeated START.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_master_writer_if.sv | 27 ++
 rtl/i2c_scl_gen.sv | 33 +++
 rtl/i2c_master_writer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the PID gain-configuration I2C master.
package i2c_pkg;

  // Default 7-bit address of the on-chip PID register slave
  localparam logic [6:0] DEVICE_ADDRESS_DEFAULT = 7'b0110011;

  // PID gain register addresses
  localparam logic [7:0] RegKp = 8'h00;
  localparam logic [7:0] RegKi = 8'h01;
  localparam logic [7:0] RegKd = 8'h02;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StDevAddr,
    StRwBit,
    StAddrAck,
    StRegAddr,
    StRegAck,
    StWrite,
    StWriteAck,
    StRestart,
    StRead,
    StMasterNack,
    StStop
  } state_t;

endpackage

// File: rtl/i2c_master_writer_if.sv
// Host handshake and pad signals of the I2C master.
interface i2c_master_writer_if;
  logic       ena;
  logic       start;
  logic       rw;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       nack;
  logic       SCL_out;
  logic       SDA_out;
  logic       SDA_in;

  // Controller side
  modport master (
    input  ena, start, rw, reg_addr, wr_data, SDA_in,
    output rd_data, busy, done, nack, SCL_out, SDA_out
  );

  // Host / pad side
  modport slave (
    output ena, start, rw, reg_addr, wr_data, SDA_in,
    input  rd_data, busy, done, nack, SCL_out, SDA_out
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// Quarter-period timer: tick on every QTR_DIV clk, 2-bit phase stepping Q0..Q3.
module i2c_scl_gen #(
  parameter int unsigned QTR_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_phase
);

  localparam int unsigned CntW = (QTR_DIV > 2) ? $clog2(QTR_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_phase;

  assign o_tick  = i_en && (r_cnt == CntW'(QTR_DIV - 1));
  assign o_phase = r_phase;

  // Count quarters only while enabled; hold at Q0 otherwise
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (o_tick) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_cnt   <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_writer.sv
// I2C master for single-byte register writes/reads to the PID register slave.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDRESS = DEVICE_ADDRESS_DEFAULT,
  parameter int unsigned QTR_DIV        = 4
) (
  input logic                 clk,
  input logic                 rst,
  i2c_master_writer_if.master bus
);

  state_t     r_state;
  logic       r_busy, r_done, r_nack, r_rw, r_second, r_scl, r_sda;
  logic [7:0] r_reg_addr, r_wr_data, r_shift, r_rd_data;
  logic [2:0] r_bit_idx;
  logic       w_tick, w_bit_end, w_scl, w_sda;
  logic [1:0] w_phase;

  i2c_scl_gen #(
    .QTR_DIV(QTR_DIV)
  ) u_scl_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_busy),
    .o_tick (w_tick),
    .o_phase(w_phase)
  );

  assign w_bit_end = w_tick && (w_phase == 2'd3);

  // Line levels for the current state and quarter (registered below)
  always_comb begin
    w_scl = w_phase[1];
    w_sda = 1'b1;
    case (r_state)
      StIdle:    w_scl = 1'b1;
      StStart: begin
        w_scl = 1'b1;
        w_sda = ~w_phase[1];
      end
      StDevAddr: w_sda = DEVICE_ADDRESS[r_bit_idx];
      StRwBit:   w_sda = r_second;
      StRegAddr: w_sda = r_reg_addr[r_bit_idx];
      StWrite:   w_sda = r_wr_data[r_bit_idx];
      StRestart: w_sda = (w_phase != 2'd3);
      StStop:    w_sda = (w_phase == 2'd3);
      default:   w_sda = 1'b1;
    endcase
  end

  // Transaction FSM; state advances at the end of each bit's Q3
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_nack     <= 1'b0;
      r_rd_data  <= '0;
      r_bit_idx  <= 3'd7;
      r_scl      <= 1'b1;
      r_sda      <= 1'b1;
      r_rw       <= 1'b0;
      r_second   <= 1'b0;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_shift    <= '0;
    end else begin
      r_done <= 1'b0;
      r_scl  <= w_scl;
      r_sda  <= w_sda;
      case (r_state)
        StIdle: if (bus.ena && bus.start) begin
          r_rw       <= bus.rw;
          r_reg_addr <= bus.reg_addr;
          r_wr_data  <= bus.wr_data;
          r_nack     <= 1'b0;
          r_busy     <= 1'b1;
          r_second   <= 1'b0;
          r_state    <= StStart;
        end
        StStart: if (w_bit_end) begin
          r_bit_idx <= 3'd6;
          r_state   <= StDevAddr;
        end
        StDevAddr: if (w_bit_end) begin
          if (r_bit_idx == 3'd0) r_state <= StRwBit;
          else                   r_bit_idx <= r_bit_idx - 3'd1;
        end
        StRwBit: if (w_bit_end) r_state <= StAddrAck;
        StAddrAck: if (w_bit_end) begin
          r_bit_idx <= 3'd7;
          if (bus.SDA_in) begin
            r_nack  <= 1'b1;
            r_state <= StStop;
          end else begin
            r_state <= r_second ? StRead : StRegAddr;
          end
        end
        StRegAddr: if (w_bit_end) begin
          if (r_bit_idx == 3'd0) r_state <= StRegAck;
          else                   r_bit_idx <= r_bit_idx - 3'd1;
        end
        StRegAck: if (w_bit_end) begin
          r_bit_idx <= 3'd7;
          if (bus.SDA_in) begin
            r_nack  <= 1'b1;
            r_state <= StStop;
          end else begin
            r_state <= r_rw ? StRestart : StWrite;
          end
        end
        StWrite: if (w_bit_end) begin
          if (r_bit_idx == 3'd0) r_state <= StWriteAck;
          else                   r_bit_idx <= r_bit_idx - 3'd1;
        end
        StWriteAck: if (w_bit_end) begin
          r_nack  <= r_nack | bus.SDA_in;
          r_state <= StStop;
        end
        StRestart: if (w_bit_end) begin
          r_second  <= 1'b1;
          r_bit_idx <= 3'd6;
          r_state   <= StDevAddr;
        end
        StRead: if (w_bit_end) begin
          r_shift <= {r_shift[6:0], bus.SDA_in};
          if (r_bit_idx == 3'd0) r_state <= StMasterNack;
          else                   r_bit_idx <= r_bit_idx - 3'd1;
        end
        StMasterNack: if (w_bit_end) begin
          r_rd_data <= r_shift;
          r_state   <= StStop;
        end
        StStop: if (w_bit_end) begin
          r_bit_idx <= 3'd7;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.nack    = r_nack;
  assign bus.SCL_out = r_scl;
  assign bus.SDA_out = r_sda;

endmodule
